seg7_scan_ctrl: RTL

//  Multiplexed 4-digit seven-segment display scanner. Time-slices one shared segment bus across four

---
 rtl/seg7_scan_ctrl_pkg.sv | 37 +++
 rtl/seg7_scan_ctrl_if.sv | 11 +
 rtl/seg7_scan_ctrl_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Digit 0 is the leftmost anode bit, so idx0 drives an=4'b0111.
  function automatic logic [3:0] digit_sel(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the display scanner: one 16-bit display word with per-digit dp and enable mask.
interface seg7_scan_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_mask;

  modport master (output wr_valid, wr_data, wr_dp, wr_mask, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_dp, wr_mask, output wr_ready);
endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed seven-segment scanner with per-slot blanking and frame-aligned
// double-buffered display words.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  wr,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             frame_tick
);

  localparam int              CW         = $clog2(SLOT_CYC);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   pend_data_q, act_data_q;
  logic [3:0]    pend_dp_q, pend_mask_q;
  logic [3:0]    act_dp_q, act_mask_q;
  logic          ready_q;
  logic          tick_q;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          lit_d;
  logic          wr_fire;
  logic          commit;

  // Pending is full exactly when ready is low, so ready doubles as the buffer-empty flag.
  assign wr_fire = wr.wr_valid & ready_q;
  assign commit  = tick_q & ~ready_q;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = S_BLANK;
      idx_d   = idx_q + 2'd1;
    end else if (cnt_q == BLANK_LAST) begin
      state_d = S_ON;
    end
  end

  assign nib   = act_data_q[{idx_d, 2'b00} +: 4];
  assign lit_d = (state_d == S_ON) & act_mask_q[idx_d];

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

  // NOTE: outputs are registered from the next-state values so that an/seg/dp line up with
  // state_q/idx_q in the same cycle instead of lagging the FSM by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the word buffers are ordinary flops, not a RAM, and must clear so the display
      // stays blank after reset and any in-flight write is dropped.
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      tick_q      <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_mask_q <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= (idx_d == 2'd3) && (cnt_d == CNT_LAST);
      an_q    <= lit_d ? digit_sel(idx_d) : AN_OFF;
      seg_q   <= lit_d ? seg_dec : SEG_OFF;
      dp_q    <= ~(lit_d & act_dp_q[idx_d]);

      if (wr_fire) begin
        pend_data_q <= wr.wr_data;
        pend_dp_q   <= wr.wr_dp;
        pend_mask_q <= wr.wr_mask;
        ready_q     <= 1'b0;
      end else if (commit) begin
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        act_mask_q  <= pend_mask_q;
        ready_q     <= 1'b1;
      end
    end
  end

  assign wr.wr_ready = ready_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_tick  = tick_q;

endmodule
